// File: rtl/fft_pkg.sv
// fft_pkg: definitions shared by the FFT datapath and its result streamer.
//   FFT_N / FFT_LOG2N  : transform size (16 points, 4 index bits)
//   FFT_WIDTH          : default bits per real or imaginary sample (Q15)
//   streamer_state_t   : control states of fft_result_streamer
//   bitrev4            : 4-bit index reversal used for bit-reversed readout
package fft_pkg;

  localparam int FFT_N     = 16;
  localparam int FFT_LOG2N = 4;
  localparam int FFT_WIDTH = 16;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } streamer_state_t;

  function automatic logic [FFT_LOG2N-1:0] bitrev4(input logic [FFT_LOG2N-1:0] idx);
    logic [FFT_LOG2N-1:0] r;
    for (int b = 0; b < FFT_LOG2N; b++) begin
      r[b] = idx[FFT_LOG2N-1-b];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_result_streamer.sv
// fft_result_streamer: captures the 16-bin parallel FFT result on the fft_done
// pulse and streams it out one complex bin per valid/ready transfer.
//
// Configuration macro:
//   FFT_STREAM_BITREV_EN  defined   -> slots read in bit-reversed order of the
//                                      sequence counter (0, 8, 4, 12, ...)
//                         undefined -> natural order 0..15
//
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   fft_done        : one-cycle pulse, FFT buses valid in this cycle
//   fft_data_real   : N packed real samples, bin k at [WIDTH*k +: WIDTH]
//   fft_data_imag   : N packed imaginary samples, same packing
//   out_valid       : bin on out_real/out_imag is valid
//   out_ready       : downstream accepts the bin
//   out_real/imag   : samples of the presented slot (unmodified)
//   out_index       : slot being presented
//   out_last        : high with the 16th bin of the frame
//   busy            : a frame is held or being streamed
//   overrun         : one-cycle pulse when an incoming frame is dropped
module fft_result_streamer
  import fft_pkg::*;
#(
  parameter int WIDTH = FFT_WIDTH,
  parameter int N     = FFT_N
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    fft_done,
  input  logic [WIDTH*N-1:0]      fft_data_real,
  input  logic [WIDTH*N-1:0]      fft_data_imag,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [WIDTH-1:0] out_real,
  output logic signed [WIDTH-1:0] out_imag,
  output logic [FFT_LOG2N-1:0]    out_index,
  output logic                    out_last,
  output logic                    busy,
  output logic                    overrun
);

  if (N != FFT_N) begin : g_bad_n
    $error("fft_result_streamer: N must be %0d", FFT_N);
  end

  localparam logic [FFT_LOG2N-1:0] LAST_CNT = FFT_LOG2N'(FFT_N - 1);

  streamer_state_t            state;
  logic [FFT_LOG2N-1:0]       cnt;
  logic signed [WIDTH-1:0]    frame_real [FFT_N];
  logic signed [WIDTH-1:0]    frame_imag [FFT_N];

  logic                       streaming;
  logic                       last_xfer;
  logic                       capture;
  logic [FFT_LOG2N-1:0]       sel;

  assign streaming = (state == STREAM);
  assign last_xfer = streaming && out_ready && (cnt == LAST_CNT);
  // A new frame is taken when nothing is held, or when the held frame leaves
  // on this very edge; that lets back-to-back frames stream without a gap.
  assign capture   = fft_done && (!streaming || last_xfer);

`ifdef FFT_STREAM_BITREV_EN
  assign sel = bitrev4(cnt);
`else
  assign sel = cnt;
`endif

  // Control: state, sequence counter, overrun flag
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      overrun <= 1'b0;
    end else begin
      overrun <= fft_done && streaming && !last_xfer;
      if (capture) begin
        state <= STREAM;
        cnt   <= '0;
      end else if (last_xfer) begin
        state <= IDLE;
        cnt   <= '0;
      end else if (streaming && out_ready) begin
        cnt   <= cnt + 1'b1;
      end
    end
  end

  // Frame register: loaded whole on capture, untouched while streaming
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < FFT_N; i++) begin
        frame_real[i] <= '0;
        frame_imag[i] <= '0;
      end
    end else if (capture) begin
      for (int i = 0; i < FFT_N; i++) begin
        frame_real[i] <= fft_data_real[WIDTH*i +: WIDTH];
        frame_imag[i] <= fft_data_imag[WIDTH*i +: WIDTH];
      end
    end
  end

  // Outputs decode straight from registered state; out_ready only steers
  // the next-state logic, never out_valid.
  always_comb begin
    out_valid = streaming;
    busy      = streaming;
    out_last  = streaming && (cnt == LAST_CNT);
    out_index = streaming ? sel : '0;
    out_real  = streaming ? frame_real[sel] : '0;
    out_imag  = streaming ? frame_imag[sel] : '0;
  end

endmodule

// File: tb/tb_fft_result_streamer.sv
// Self-checking bench for fft_result_streamer: directed scenarios plus a
// randomized stretch, compared each cycle against a queue-based model of the
// expected bin stream.
module tb_fft_result_streamer;
  import fft_pkg::*;

  localparam int W = 16;
  localparam int NB = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              fft_done;
  logic [W*NB-1:0]   fft_data_real;
  logic [W*NB-1:0]   fft_data_imag;
  logic              out_valid;
  logic              out_ready;
  logic signed [W-1:0] out_real;
  logic signed [W-1:0] out_imag;
  logic [3:0]        out_index;
  logic              out_last;
  logic              busy;
  logic              overrun;

  fft_result_streamer #(.WIDTH(W), .N(NB)) dut (
    .clk(clk), .rst(rst), .fft_done(fft_done),
    .fft_data_real(fft_data_real), .fft_data_imag(fft_data_imag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_real(out_real), .out_imag(out_imag), .out_index(out_index),
    .out_last(out_last), .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    int idx;
    int re;
    int im;
  } bin_t;

  bin_t q[$];
  int   fr_re [NB];
  int   fr_im [NB];
  bit   exp_ovr;
  int   total;
  int   bad;

  function automatic int slot_of(input int i);
`ifdef FFT_STREAM_BITREV_EN
    int r;
    r = 0;
    for (int b = 0; b < 4; b++) r = r * 2 + ((i >> b) & 1);
    return r;
`else
    return i;
`endif
  endfunction

  task automatic chk(input string tag, input int obs, input int expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic load_frame();
    for (int k = 0; k < NB; k++) begin
      fft_data_real[W*k +: W] = W'(fr_re[k]);
      fft_data_imag[W*k +: W] = W'(fr_im[k]);
    end
  endtask

  task automatic check_outputs();
    bit v;
    v = (q.size() > 0);
    chk("out_valid", int'(out_valid), int'(v));
    chk("busy", int'(busy), int'(v));
    chk("overrun", int'(overrun), int'(exp_ovr));
    if (v) begin
      chk("out_index", int'(out_index), q[0].idx);
      chk("out_real", int'(out_real), q[0].re);
      chk("out_imag", int'(out_imag), q[0].im);
      chk("out_last", int'(out_last), int'(q.size() == 1));
    end else begin
      chk("idle_last", int'(out_last), 0);
      chk("idle_real", int'(out_real), 0);
      chk("idle_imag", int'(out_imag), 0);
      chk("idle_index", int'(out_index), 0);
    end
  endtask

  // One clock: check present outputs, apply inputs, advance the model.
  task automatic step(input bit done, input bit rdy, input bit rs);
    bit was_busy;
    check_outputs();
    fft_done  = done;
    out_ready = rdy;
    rst       = rs;
    if (rs) begin
      q.delete();
      exp_ovr = 1'b0;
    end else begin
      was_busy = (q.size() > 0);
      if (was_busy && rdy) void'(q.pop_front());
      exp_ovr = 1'b0;
      if (done) begin
        if (q.size() == 0) begin
          for (int i = 0; i < NB; i++) begin
            bin_t b;
            b.idx = slot_of(i);
            b.re  = fr_re[b.idx];
            b.im  = fr_im[b.idx];
            q.push_back(b);
          end
        end else begin
          exp_ovr = 1'b1;
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
    fft_done = 1'b0;
    rst      = 1'b0;
  endtask

  task automatic rand_frame();
    for (int k = 0; k < NB; k++) begin
      fr_re[k] = int'($signed(16'($urandom)));
      fr_im[k] = int'($signed(16'($urandom)));
    end
    load_frame();
  endtask

  initial begin
    total = 0;
    bad = 0;
    exp_ovr = 1'b0;
    rst = 1'b1;
    fft_done = 1'b0;
    out_ready = 1'b0;
    for (int k = 0; k < NB; k++) begin
      fr_re[k] = 0;
      fr_im[k] = 0;
    end
    load_frame();
    @(negedge clk);
    // reset held (fft_done asserted alongside it must be ignored)
    step(1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0);

    // impulse frame, ready always high
    fr_re[0] = 32767;
    load_frame();
    step(1'b1, 1'b1, 1'b0);
    for (int c = 0; c < 18; c++) step(1'b0, 1'b1, 1'b0);

    // ramp with ready pattern 1,0,0
    for (int k = 0; k < NB; k++) begin
      fr_re[k] = 100 * k;
      fr_im[k] = -k;
    end
    load_frame();
    step(1'b1, 1'b0, 1'b0);
    for (int c = 0; c < 52; c++) step(1'b0, (c % 3) == 0, 1'b0);

    // overrun during transfer 5
    rand_frame();
    step(1'b1, 1'b1, 1'b0);
    for (int c = 0; c < 5; c++) step(1'b0, 1'b1, 1'b0);
    rand_frame();
    step(1'b1, 1'b1, 1'b0);
    for (int c = 0; c < 14; c++) step(1'b0, 1'b1, 1'b0);

    // gapless chaining: frame B arrives with the last transfer of frame A
    rand_frame();
    step(1'b1, 1'b1, 1'b0);
    for (int c = 0; c < 15; c++) step(1'b0, 1'b1, 1'b0);
    for (int k = 0; k < NB; k++) begin
      fr_re[k] = 1000 + k;
      fr_im[k] = k;
    end
    load_frame();
    step(1'b1, 1'b1, 1'b0);
    for (int c = 0; c < 18; c++) step(1'b0, 1'b1, 1'b0);

    // reset at transfer 7, then a fresh frame from index 0
    rand_frame();
    step(1'b1, 1'b1, 1'b0);
    for (int c = 0; c < 6; c++) step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b0);
    rand_frame();
    step(1'b1, 1'b1, 1'b0);
    for (int c = 0; c < 18; c++) step(1'b0, 1'b1, 1'b0);

    // randomized traffic
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 9) == 0) rand_frame();
      step($urandom_range(0, 9) == 0, $urandom_range(0, 3) != 0,
           $urandom_range(0, 79) == 0);
    end
    for (int c = 0; c < 40; c++) step(1'b0, 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fft_result_streamer.md
# fft_result_streamer

Consumes the 16-bin parallel result of the radix-2² 16-point FFT and delivers it downstream as a serial stream of one complex bin per transfer under a valid/ready handshake. The streamer captures the FFT output bus on the FFT `done` pulse, so the FFT can start its next frame immediately. It sits between the FFT core and any serial consumer, such as a magnitude or peak-detect stage or a host readout FIFO.

## Interface
- `WIDTH`, 16: bits per real or imaginary sample, two's complement (Q15 at default).
- `N`, 16: bins per frame; fixed at 16, range-checked at elaboration.
- `clk`  in  1: single clock; everything is sampled on its rising edge.
- `rst`  in  1: reset, synchronous and active-high.
- `fft_done`  in  1: one-cycle pulse; FFT result on the data buses is valid in this cycle.
- `fft_data_real`  in  WIDTH*N: bin k occupies bits [WIDTH*k +: WIDTH].
- `fft_data_imag`  in  WIDTH*N: same packing as `fft_data_real`.
- `out_valid`  out  1: output bin is valid.
- `out_ready`  in  1: downstream accepts the bin.
- `out_real`  out  WIDTH: real part of the current bin.
- `out_imag`  out  WIDTH: imaginary part of the current bin.
- `out_index`  out  4: bin slot being presented.
- `out_last`  out  1: high with the 16th bin of the frame.
- `busy`  out  1: a frame is held or being streamed.
- `overrun`  out  1: one-cycle pulse when a frame is dropped.

## Operation
- FSM states:
  - IDLE: `busy`=0, `out_valid`=0.
  - STREAM: `busy`=1, `out_valid`=1.
- IDLE with `fft_done`=1: capture both buses into a 2×N×WIDTH frame register, clear the sequence counter `cnt`, go to STREAM.
- STREAM:
  - Present slot `sel = cnt`, or `bitrev4(cnt)` when `FFT_STREAM_BITREV_EN` is defined.
  - `out_real` and `out_imag` carry that slot's samples.
  - `out_index = sel`; `out_last = (cnt == 15)`.
- A transfer occurs on a cycle with `out_valid && out_ready`. On a transfer, `cnt` increments; a transfer with `out_last` set returns the FSM to IDLE.
- While `out_valid && !out_ready`, all outputs are held stable and `cnt` does not change.
- `fft_done` in STREAM with no last-transfer in the same cycle: the new frame is dropped, `overrun` pulses for one cycle, and the held frame continues unaffected.
- `fft_done` in the same cycle as the last transfer: the new frame is captured, the FSM stays in STREAM with `cnt`=0, and `overrun` stays 0.
- Samples pass through unmodified: no scaling or rounding, and widths are preserved.

## Timing
- Reset values: `out_valid`=0, `out_last`=0, `busy`=0, `overrun`=0, `out_index`=0, `out_real`=0, `out_imag`=0. The frame register and `cnt` are cleared; the FSM is in IDLE.
- `rst` asserted mid-frame: at the next edge the FSM goes to IDLE and the frame is discarded. A `fft_done` in the same cycle as `rst` is ignored.
- Latency: `fft_done` sampled at edge t gives `out_valid`=1 with bin 0 from edge t+1.
- Throughput: one bin per cycle with `out_ready` held high, so a frame takes 16 cycles. Back-to-back frames are gapless if `fft_done` coincides with the last transfer.
- All outputs are registered or decoded directly from registered state; there is no combinational path from `out_ready` to `out_valid`.
- `overrun` is registered and asserts the cycle after the dropped `fft_done`.

## Configuration
- `FFT_STREAM_BITREV_EN` defined: slots are read in bit-reversed order of `cnt` (0, 8, 4, 12, 2, …, 15), for use with FFT builds that emit bit-reversed bins. `out_index` reports the slot read.
- Macro undefined: natural order 0..15, with `out_index == cnt`.

## Structure
- Shared package `fft_pkg` holds:
  - `FFT_N` = 16 and `FFT_LOG2N` = 4;
  - the default `WIDTH`;
  - the `streamer_state_t` enum {IDLE, STREAM};
  - the function `bitrev4`.
- No sub-module. Slot selection is an N:1 mux inside the block; the frame register is a flat array.

## Test plan
- Impulse frame: load real slot 0 = 32767 and all other slots 0, pulse `fft_done`, hold `out_ready`=1. Required: 16 consecutive transfers; bin 0 = 32767, bins 1–15 = 0; `out_last` only on index 15; `busy` drops after the last transfer.
- Ramp with backpressure: real[k] = 100·k, imag[k] = −k. Toggle `out_ready` 1,0,0,1,… Required: each value is held stable while stalled, and the accepted sequence is exactly 0/0, 100/−1, …, 1500/−15.
- Overrun: pulse `fft_done` at transfer 5 of a frame. Required: `overrun` = 1 for one cycle, and the remaining bins still come from the original frame.
- Gapless chaining: pulse `fft_done` coincident with the last transfer, carrying frame B with real[k] = 1000+k. Required: the next cycle shows index 0 with value 1000, and `overrun` stays 0.
- Reset mid-stream: assert `rst` at transfer 7. Required: next cycle `out_valid`=0 and `busy`=0; a subsequent frame starts again from index 0.
- Bit-reverse build with `FFT_STREAM_BITREV_EN`: ramp input. Required: `out_index` and real values follow the order 0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15 (real = 100·index).
